// File: rtl/mlp_infer_sequencer.sv
// MLP inference control: sequences NUM_LAYERS layer engines, then a pipelined argmax over the logits memory.
// Optional: define MLP_ARGMAX_MARGIN_EN to add top-2 margin and low-confidence outputs.
module mlp_infer_sequencer #(
    parameter int NUM_LAYERS     = 2,
    parameter int NUM_CLASSES    = 10,
    parameter int LOGIT_W        = 32,
    parameter int CLS_W          = $clog2(NUM_CLASSES),
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TO_W           = 24
`ifdef MLP_ARGMAX_MARGIN_EN
    ,
    parameter int MARGIN_THRESH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic [CLS_W-1:0]      predicted_class,
    output logic [LOGIT_W-1:0]    max_logit,
    output logic                  timeout_err,
`ifdef MLP_ARGMAX_MARGIN_EN
    output logic [LOGIT_W:0]      margin,
    output logic                  low_conf,
`endif
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [CLS_W-1:0]      logit_addr,
    input  logic [LOGIT_W-1:0]    logit_rdata
);

    localparam int                LIDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [CLS_W-1:0]  LAST_CLS   = CLS_W'(NUM_CLASSES - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);
    localparam bit                WD_EN      = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, LAYER, ARGMAX, FINISH} state_e;

    state_e                      state_q, state_d;
    logic [LIDX_W-1:0]           cur_q, cur_d;
    logic [TO_W-1:0]             wd_q, wd_d;
    logic [CLS_W-1:0]            addr_q, addr_d;
    logic                        iss_q, iss_d;
    logic                        rd_vld_q, rd_vld_d;
    logic [CLS_W-1:0]            rd_idx_q, rd_idx_d;
    logic signed [LOGIT_W-1:0]   run_max_q, run_max_d;
    logic [CLS_W-1:0]            run_idx_q, run_idx_d;
    logic [NUM_LAYERS-1:0]       lstart_q, lstart_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        res_vld_q, res_vld_d;
    logic [CLS_W-1:0]            cls_q, cls_d;
    logic [LOGIT_W-1:0]          max_q, max_d;
    logic                        to_err_q, to_err_d;
    logic signed [LOGIT_W-1:0]   rdata_s;
`ifdef MLP_ARGMAX_MARGIN_EN
    logic signed [LOGIT_W-1:0]   sec_q, sec_d;
    logic                        sec_vld_q, sec_vld_d;
    logic [LOGIT_W:0]            margin_q, margin_d;
    logic                        low_conf_q, low_conf_d;
    logic [LOGIT_W:0]            margin_calc;

    // Sign-extend before subtracting so the full signed range fits the unsigned difference.
    assign margin_calc = {run_max_d[LOGIT_W-1], run_max_d} - {sec_d[LOGIT_W-1], sec_d};
`endif

    assign rdata_s = $signed(logit_rdata);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cur_d     = cur_q;
        wd_d      = wd_q;
        addr_d    = addr_q;
        iss_d     = 1'b0;
        rd_vld_d  = 1'b0;
        rd_idx_d  = addr_q;
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        lstart_d  = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        res_vld_d = res_vld_q;
        cls_d     = cls_q;
        max_d     = max_q;
        to_err_d  = to_err_q;
`ifdef MLP_ARGMAX_MARGIN_EN
        sec_d      = sec_q;
        sec_vld_d  = sec_vld_q;
        margin_d   = margin_q;
        low_conf_d = low_conf_q;
`endif

        // Running argmax on the read data returned for the previous cycle's address.
        if (rd_vld_q) begin
            if (rd_idx_q == '0) begin
                run_max_d = rdata_s;
                run_idx_d = '0;
`ifdef MLP_ARGMAX_MARGIN_EN
                sec_vld_d = 1'b0;
`endif
            end else if (rdata_s > run_max_q) begin
`ifdef MLP_ARGMAX_MARGIN_EN
                sec_d     = run_max_q;
                sec_vld_d = 1'b1;
`endif
                run_max_d = rdata_s;
                run_idx_d = rd_idx_q;
            end else begin
`ifdef MLP_ARGMAX_MARGIN_EN
                if (!sec_vld_q || (rdata_s > sec_q)) begin
                    sec_d     = rdata_s;
                    sec_vld_d = 1'b1;
                end
`endif
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LAYER;
                    cur_d       = '0;
                    wd_d        = '0;
                    lstart_d[0] = 1'b1;
                    busy_d      = 1'b1;
                    res_vld_d   = 1'b0;
                    cls_d       = '0;
                    max_d       = '0;
                    to_err_d    = 1'b0;
`ifdef MLP_ARGMAX_MARGIN_EN
                    margin_d    = '0;
                    low_conf_d  = 1'b0;
`endif
                end
            end
            LAYER: begin
                if (layer_done[cur_q]) begin
                    wd_d = '0;
                    if (cur_q == LAST_LAYER) begin
                        state_d = ARGMAX;
                        addr_d  = '0;
                        iss_d   = 1'b1;
                    end else begin
                        cur_d           = cur_q + 1'b1;
                        lstart_d[cur_d] = 1'b1;
                    end
                end else if (WD_EN && (wd_q == TO_LIMIT)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    res_vld_d = 1'b0;
                    to_err_d  = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ARGMAX: begin
                if (iss_q) begin
                    rd_vld_d = 1'b1;
                    rd_idx_d = addr_q;
                    if (addr_q != LAST_CLS) begin
                        addr_d = addr_q + 1'b1;
                        iss_d  = 1'b1;
                    end
                end
                if (rd_vld_q && (rd_idx_q == LAST_CLS)) begin
                    state_d   = FINISH;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    res_vld_d = 1'b1;
                    cls_d     = run_idx_d;
                    max_d     = run_max_d;
`ifdef MLP_ARGMAX_MARGIN_EN
                    margin_d   = margin_calc;
                    low_conf_d = (margin_calc < (LOGIT_W+1)'(MARGIN_THRESH));
`endif
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over any same-cycle completion, layer advance or timeout.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            lstart_d  = '0;
            done_d    = 1'b0;
            iss_d     = 1'b0;
            rd_vld_d  = 1'b0;
            res_vld_d = res_vld_q;
            cls_d     = cls_q;
            max_d     = max_q;
            to_err_d  = to_err_q;
`ifdef MLP_ARGMAX_MARGIN_EN
            margin_d   = margin_q;
            low_conf_d = low_conf_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            wd_q      <= '0;
            addr_q    <= '0;
            iss_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            lstart_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_vld_q <= 1'b0;
            cls_q     <= '0;
            max_q     <= '0;
            to_err_q  <= 1'b0;
`ifdef MLP_ARGMAX_MARGIN_EN
            sec_q      <= '0;
            sec_vld_q  <= 1'b0;
            margin_q   <= '0;
            low_conf_q <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking '<=' so all updates see pre-edge values.
            state_q   <= state_d;
            cur_q     <= cur_d;
            wd_q      <= wd_d;
            addr_q    <= addr_d;
            iss_q     <= iss_d;
            rd_vld_q  <= rd_vld_d;
            rd_idx_q  <= rd_idx_d;
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            lstart_q  <= lstart_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_vld_q <= res_vld_d;
            cls_q     <= cls_d;
            max_q     <= max_d;
            to_err_q  <= to_err_d;
`ifdef MLP_ARGMAX_MARGIN_EN
            sec_q      <= sec_d;
            sec_vld_q  <= sec_vld_d;
            margin_q   <= margin_d;
            low_conf_q <= low_conf_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign result_valid    = res_vld_q;
    assign predicted_class = cls_q;
    assign max_logit       = max_q;
    assign timeout_err     = to_err_q;
    assign layer_start     = lstart_q;
    assign logit_addr      = addr_q;
`ifdef MLP_ARGMAX_MARGIN_EN
    assign margin          = margin_q;
    assign low_conf        = low_conf_q;
`endif

endmodule

// File: tb/tb_mlp_infer_sequencer.sv
// Directed, table-driven bench for mlp_infer_sequencer: argmax vectors plus timeout, abort and reset sequences.
module tb_mlp_infer_sequencer;

    localparam int NL = 2;
    localparam int NC = 10;
    localparam int LW = 32;
    localparam int CW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic [CW-1:0] predicted_class;
    logic [LW-1:0] max_logit;
    logic          timeout_err;
    logic [NL-1:0] layer_start;
    logic [NL-1:0] layer_done;
    logic [CW-1:0] logit_addr;
    logic [LW-1:0] logit_rdata;
`ifdef MLP_ARGMAX_MARGIN_EN
    logic [LW:0]   margin;
    logic          low_conf;
`endif

    logic [LW-1:0] mem [NC];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [LW-1:0] lg [NC];
        logic [CW-1:0] cls;
        logic [LW-1:0] mx;
        logic [LW:0]   mg;
        logic          lc;
        int            d0;
        int            d1;
    } vec_t;

    vec_t vecs [6];

    mlp_infer_sequencer #(
        .NUM_LAYERS(NL), .NUM_CLASSES(NC), .LOGIT_W(LW), .CLS_W(CW),
        .TIMEOUT_CYCLES(TO), .TO_W(24)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .result_valid(result_valid),
        .predicted_class(predicted_class), .max_logit(max_logit),
        .timeout_err(timeout_err),
`ifdef MLP_ARGMAX_MARGIN_EN
        .margin(margin), .low_conf(low_conf),
`endif
        .layer_start(layer_start), .layer_done(layer_done),
        .logit_addr(logit_addr), .logit_rdata(logit_rdata)
    );

    always #5 clk = ~clk;

    // Logits memory with one cycle of read latency.
    always @(posedge clk) logit_rdata <= (logit_addr < CW'(NC)) ? mem[logit_addr] : '0;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_res_valid"}, result_valid, 0);
        check({tag, "_class"}, predicted_class, 0);
        check({tag, "_max"}, max_logit, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_layer_start"}, layer_start, 0);
        check({tag, "_logit_addr"}, logit_addr, 0);
`ifdef MLP_ARGMAX_MARGIN_EN
        check({tag, "_margin"}, margin, 0);
        check({tag, "_low_conf"}, low_conf, 0);
`endif
    endtask

    // Full run: start at T, layer_done[0] at T+d0, layer_done[1] at T+d1, done expected at T+d1+12.
    task automatic run_vec(input int k);
        int c;
        int waited;
        string t;
        t = $sformatf("v%0d", k);
        for (int i = 0; i < NC; i++) mem[i] = vecs[k].lg[i];
        start = 1'b1;
        tick;
        start = 1'b0;
        c = 1;
        check({t, "_busy_after_start"}, busy, 1);
        check({t, "_layer_start0"}, layer_start, 2'b01);
        check({t, "_res_valid_cleared"}, result_valid, 0);
        check({t, "_class_cleared"}, predicted_class, 0);
        while (c < vecs[k].d0) begin tick; c++; end
        layer_done = 2'b01;
        tick;
        c++;
        layer_done = '0;
        check({t, "_layer_start1"}, layer_start, 2'b10);
        while (c < vecs[k].d1) begin tick; c++; end
        layer_done = 2'b10;
        tick;
        c++;
        layer_done = '0;
        check({t, "_argmax_addr0"}, logit_addr, 0);
        check({t, "_busy_in_argmax"}, busy, 1);
        waited = 0;
        while (!done && waited < 40) begin tick; waited++; end
        check({t, "_done_latency"}, waited, 11);
        check({t, "_busy_at_done"}, busy, 0);
        check({t, "_res_valid"}, result_valid, 1);
        check({t, "_class"}, predicted_class, vecs[k].cls);
        check({t, "_max_logit"}, max_logit, vecs[k].mx);
`ifdef MLP_ARGMAX_MARGIN_EN
        check({t, "_margin"}, margin, vecs[k].mg);
        check({t, "_low_conf"}, low_conf, vecs[k].lc);
`endif
        tick;
        check({t, "_done_pulse"}, done, 0);
        check({t, "_class_hold"}, predicted_class, vecs[k].cls);
        check({t, "_res_valid_hold"}, result_valid, 1);
    endtask

    initial begin
        int waited;
        logic seen_done;

        for (int k = 0; k < 6; k++) for (int i = 0; i < NC; i++) vecs[k].lg[i] = '0;
        // Single peak, spec timing T+5 / T+9.
        vecs[0].lg[7] = 32'd500;
        vecs[0].cls = 4'd7; vecs[0].mx = 32'd500; vecs[0].mg = 33'd500; vecs[0].lc = 1'b0;
        vecs[0].d0 = 5; vecs[0].d1 = 9;
        // Tie of negatives: lowest index wins; layer_done coincident with layer_start.
        for (int i = 0; i < NC; i++) vecs[1].lg[i] = -32'sd100;
        vecs[1].lg[3] = -32'sd4; vecs[1].lg[8] = -32'sd4;
        vecs[1].cls = 4'd3; vecs[1].mx = -32'sd4; vecs[1].mg = 33'd0; vecs[1].lc = 1'b1;
        vecs[1].d0 = 1; vecs[1].d1 = 2;
        // All at the most negative value.
        for (int i = 0; i < NC; i++) vecs[2].lg[i] = 32'h8000_0000;
        vecs[2].cls = 4'd0; vecs[2].mx = 32'h8000_0000; vecs[2].mg = 33'd0; vecs[2].lc = 1'b1;
        vecs[2].d0 = 3; vecs[2].d1 = 6;
        // Close second: margin 10.
        for (int i = 0; i < NC; i++) vecs[3].lg[i] = -32'sd7;
        vecs[3].lg[2] = 32'd500; vecs[3].lg[5] = 32'd490;
        vecs[3].cls = 4'd2; vecs[3].mx = 32'd500; vecs[3].mg = 33'd10; vecs[3].lc = 1'b1;
        vecs[3].d0 = 2; vecs[3].d1 = 4;
        // Max at the last index, second at index 0: margin 100.
        vecs[4].lg[0] = 32'd400; vecs[4].lg[9] = 32'd500;
        vecs[4].cls = 4'd9; vecs[4].mx = 32'd500; vecs[4].mg = 33'd100; vecs[4].lc = 1'b0;
        vecs[4].d0 = 4; vecs[4].d1 = 7;
        // Full-range margin: max positive vs -1.
        for (int i = 0; i < NC; i++) vecs[5].lg[i] = 32'hFFFF_FFFF;
        vecs[5].lg[0] = 32'h7FFF_FFFF;
        vecs[5].cls = 4'd0; vecs[5].mx = 32'h7FFF_FFFF; vecs[5].mg = 33'h0_8000_0000; vecs[5].lc = 1'b0;
        vecs[5].d0 = 2; vecs[5].d1 = 3;

        rst = 1'b1; start = 1'b0; abort = 1'b0; layer_done = '0;
        for (int i = 0; i < NC; i++) mem[i] = '0;
        repeat (3) tick;
        check_all_zero("reset");
        rst = 1'b0;
        tick;

        for (int k = 0; k < 6; k++) run_vec(k);

        // Watchdog: layer 1 never completes; done exactly 17 cycles after layer_start[1].
        start = 1'b1; tick; start = 1'b0;
        repeat (4) tick;
        layer_done = 2'b01; tick; layer_done = '0;
        check("to_layer_start1", layer_start, 2'b10);
        waited = 0;
        while (!done && waited < 60) begin tick; waited++; end
        check("to_latency", waited, 17);
        check("to_err_set", timeout_err, 1);
        check("to_res_valid", result_valid, 0);
        check("to_busy", busy, 0);
        check("to_class", predicted_class, 0);
        check("to_max", max_logit, 0);
        tick;
        check("to_done_pulse", done, 0);
        check("to_err_sticky", timeout_err, 1);
        start = 1'b1; tick; start = 1'b0;
        check("to_err_cleared", timeout_err, 0);
        check("to_restart_busy", busy, 1);
        abort = 1'b1; tick; abort = 1'b0;
        check("abort_layer_busy", busy, 0);
        check("abort_layer_ls", layer_start, 0);
        check("abort_layer_done", done, 0);

        // Protocol robustness: start during LAYER, stray layer_done[1], abort in ARGMAX.
        for (int i = 0; i < NC; i++) mem[i] = vecs[0].lg[i];
        start = 1'b1; tick; start = 1'b0;
        tick;
        start = 1'b1; layer_done = 2'b10;
        tick;
        start = 1'b0; layer_done = '0;
        check("rob_start_ignored", layer_start, 0);
        check("rob_busy", busy, 1);
        tick; tick;
        layer_done = 2'b01; tick; layer_done = '0;
        check("rob_layer_start1", layer_start, 2'b10);
        repeat (3) tick;
        layer_done = 2'b10; tick; layer_done = '0;
        check("rob_addr0", logit_addr, 0);
        repeat (3) tick;
        check("rob_addr3", logit_addr, 3);
        abort = 1'b1; tick; abort = 1'b0;
        check("rob_abort_busy", busy, 0);
        check("rob_abort_done", done, 0);
        check("rob_abort_res_valid", result_valid, 0);
        seen_done = 1'b0;
        repeat (20) begin tick; if (done) seen_done = 1'b1; end
        check("rob_no_done_after_abort", seen_done, 0);
        run_vec(3);

        // Reset mid-ARGMAX at D+4.
        for (int i = 0; i < NC; i++) mem[i] = vecs[4].lg[i];
        start = 1'b1; tick; start = 1'b0;
        repeat (4) tick;
        layer_done = 2'b01; tick; layer_done = '0;
        repeat (3) tick;
        layer_done = 2'b10; tick; layer_done = '0;
        repeat (3) tick;
        check("rst_pre_busy", busy, 1);
        rst = 1'b1; tick; rst = 1'b0;
        check_all_zero("rst_mid");
        tick;
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mlp_infer_sequencer.md
Name: mlp_infer_sequencer

Overview:
- Parametrised control block for N-layer fixed-point MLP inference.
- Sequences an arbitrary number of external layer engines through per-layer start/done pulses, then runs a pipelined argmax over the final logits memory.
- Reports the predicted class through a start/busy/done handshake.
- Adds a per-layer watchdog and an abort input.
- Replaces the hard-wired two-layer auto-start controller at the top level.

Parameters:
- NUM_LAYERS, 2, number of layer engines sequenced in order 0..NUM_LAYERS-1 (≥1).
- NUM_CLASSES, 10, number of logits scanned by argmax (≥2).
- LOGIT_W, 32, signed logit width.
- CLS_W, $clog2(NUM_CLASSES), class index / logit address width.
- TIMEOUT_CYCLES, 0, per-layer watchdog limit in cycles; 0 disables the watchdog.
- TO_W, 24, watchdog counter width.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request inference; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE with no done pulse.
- busy  out  1  high from the cycle after start acceptance until done/abort.
- done  out  1  one-cycle pulse at end of run (success or timeout).
- result_valid  out  1  registered with done; 1 = success, 0 = timeout; holds until next start.
- predicted_class  out  CLS_W  argmax index; holds until next start.
- max_logit  out  LOGIT_W  signed value at predicted_class; holds until next start.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared on next accepted start.
- layer_start  out  NUM_LAYERS  one-hot one-cycle start pulse to layer k.
- layer_done  in  NUM_LAYERS  done pulse from layer k.
- logit_addr  out  CLS_W  read address into the logits memory.
- logit_rdata  in  LOGIT_W  signed read data; valid exactly 1 cycle after logit_addr.

Behaviour:
- Reset values: all outputs 0; state IDLE; layer index 0; watchdog counter 0.

States:
- IDLE → LAYER when start=1.
- LAYER: drives the current layer; on layer_done[cur], moves to the next layer or to ARGMAX.
- ARGMAX: scans the logits.
- FINISH: one cycle emitting done → IDLE.

Start and layer sequencing:
- start accepted in IDLE at cycle T: busy=1 and layer_start[0]=1 at T+1; timeout_err, result_valid, predicted_class and max_logit cleared at T+1.
- start while busy is ignored with no side effect.
- layer_done[cur] high at cycle D: if cur<NUM_LAYERS-1, layer_start[cur+1] pulses at D+1.
- layer_done bits other than cur are ignored.
- layer_done coincident with its own layer_start cycle is accepted.

Argmax (after last layer_done at cycle D):
- logit_addr = 0,1,…,NUM_CLASSES-1 on cycles D+1..D+NUM_CLASSES.
- Compare occurs on the cycle after each address.
- Index 0 initialises max and index; later entries replace the max only if strictly greater (signed). Ties therefore resolve to the lowest index.
- done=1, result_valid=1 and results updated at D+NUM_CLASSES+2; busy falls in the same cycle.

Watchdog:
- Counter resets at each layer_start and increments each cycle in LAYER.
- If it reaches TIMEOUT_CYCLES before layer_done[cur], next cycle: timeout_err=1, done=1, result_valid=0, busy=0, state IDLE.
- predicted_class and max_logit stay 0 after a timeout.

Abort and reset:
- abort in any non-IDLE state: next cycle busy=0, state IDLE, layer_start=0, no done.
- Other result outputs keep their cleared values.
- abort has priority over a same-cycle layer_done or timeout.
- rst mid-operation returns every output to its reset value on the next edge, regardless of state.

Optional Feature:
MLP_ARGMAX_MARGIN_EN
- Defined: additionally tracks the second-largest logit. Extra outputs:
  - margin (LOGIT_W+1, unsigned) = max − second, registered with done.
  - low_conf (1) = margin < MARGIN_THRESH. MARGIN_THRESH is a parameter, default 16.
  - Both reset to 0 and clear on accepted start.
  - On a tie for max, margin = 0.
- Undefined: ports and second-max logic absent; behaviour otherwise identical.

Test Plan:
All scenarios use NUM_LAYERS=2, NUM_CLASSES=10, LOGIT_W=32.
1. Basic run: start at T; layer_done[0] at T+5; layer_done[1] at T+9; logits all 0 except [7]=500 → layer_start pulses at T+1/T+6; done, result_valid=1, predicted_class=7, max_logit=500 at T+21.
2. Tie and negatives: logits all −100 except [3]=[8]=−4 → predicted_class=3, max_logit=−4. All logits 0x80000000 → predicted_class=0.
3. Timeout: TIMEOUT_CYCLES=16, layer_done[1] never asserted → exactly 17 cycles after layer_start[1]: done=1, result_valid=0, timeout_err=1, busy=0. Next start clears timeout_err.
4. Protocol robustness, in one run:
   - start pulsed during LAYER → ignored.
   - Stray layer_done[1] while cur=0 → ignored.
   - abort during ARGMAX → busy=0 next cycle, no done.
   - Follow-up clean run → correct result.
5. Reset mid-ARGMAX: rst asserted at D+4 → all outputs 0 next cycle. start after release → full run succeeds.
6. MLP_ARGMAX_MARGIN_EN defined: max 500, second 490 → margin=10, low_conf=1. Max 500, second 400 → margin=100, low_conf=0.
